// File: rtl/shift_pipe_if.sv
// Request/result bundle for the shift_pipe barrel shifter.
// The Zero flag exists only when SHIFT_PIPE_ZERO_EN is defined.
interface shift_pipe_if;
    logic [15:0] In;
    logic [3:0]  Cnt;
    logic [1:0]  Op;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] Out;
    logic        out_valid;
    logic        out_ready;
`ifdef SHIFT_PIPE_ZERO_EN
    logic        Zero;

    modport master (output In, Cnt, Op, in_valid, out_ready,
                    input  in_ready, Out, out_valid, Zero);
    modport slave  (input  In, Cnt, Op, in_valid, out_ready,
                    output in_ready, Out, out_valid, Zero);
`else
    modport master (output In, Cnt, Op, in_valid, out_ready,
                    input  in_ready, Out, out_valid);
    modport slave  (input  In, Cnt, Op, in_valid, out_ready,
                    output in_ready, Out, out_valid);
`endif
endinterface

// File: rtl/shift_pipe.sv
// Four-slot pipelined 16-bit barrel shifter (stages 1, 2, 4, 8) with valid/ready flow.
// Optional registered Zero flag when SHIFT_PIPE_ZERO_EN is defined.
module shift_pipe (
    input  logic         clk,
    input  logic         rst_n,
    shift_pipe_if.slave  io_bus
);

    // One conditional shift stage: shift by n when en, else pass through.
    function automatic logic [15:0] f_stage(input logic [15:0] d,
                                            input logic [1:0]  op,
                                            input logic        en,
                                            input logic [4:0]  n);
        logic [15:0] r;
        if (!en) begin
            r = d;
        end else begin
            case (op)
                2'b00:   r = (d << n) | (d >> (5'd16 - n));
                2'b01:   r = d << n;
                2'b10:   r = 16'($signed(d) >>> n);
                2'b11:   r = d >> n;
                default: r = d;
            endcase
        end
        return r;
    endfunction

    logic [15:0] r_data [4];
    logic [3:0]  r_cnt  [4];
    logic [1:0]  r_op   [4];
    logic [3:0]  r_vld;
    logic [15:0] w_next [4];
    logic        w_adv;

    assign w_adv           = !r_vld[3] || io_bus.out_ready;
    assign io_bus.in_ready = w_adv;
    assign io_bus.Out      = r_data[3];
    assign io_bus.out_valid = r_vld[3];

    // Next data for each slot: slot k applies a shift of 2^k under cnt bit k.
    always_comb begin
        w_next[0] = f_stage(io_bus.In, io_bus.Op, io_bus.Cnt[0], 5'd1);
        w_next[1] = f_stage(r_data[0], r_op[0], r_cnt[0][1], 5'd2);
        w_next[2] = f_stage(r_data[1], r_op[1], r_cnt[1][2], 5'd4);
        w_next[3] = f_stage(r_data[2], r_op[2], r_cnt[2][3], 5'd8);
    end

    // Pipeline slots: the whole pipe advances together or freezes together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                r_data[k] <= 16'h0000;
                r_cnt[k]  <= 4'h0;
                r_op[k]   <= 2'b00;
            end
        end else if (w_adv) begin
            r_vld     <= {r_vld[2:0], io_bus.in_valid};
            r_data[0] <= w_next[0];
            r_cnt[0]  <= io_bus.Cnt;
            r_op[0]   <= io_bus.Op;
            for (int k = 1; k < 4; k++) begin
                r_data[k] <= w_next[k];
                r_cnt[k]  <= r_cnt[k-1];
                r_op[k]   <= r_op[k-1];
            end
        end else begin
            r_vld <= r_vld;
        end
    end

`ifdef SHIFT_PIPE_ZERO_EN
    logic r_zero;

    assign io_bus.Zero = r_zero;

    // Zero flag loads alongside slot 4 so it always describes Out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_zero <= 1'b1;
        end else if (w_adv) begin
            r_zero <= (w_next[3] == 16'h0000);
        end else begin
            r_zero <= r_zero;
        end
    end
`endif

endmodule

// File: tb/tb_shift_pipe.sv
// Directed and randomized self-checking bench for shift_pipe.
module tb_shift_pipe;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    shift_pipe_if bus ();

    shift_pipe dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] v_in  [8];
    logic [3:0]  v_cnt [8];
    logic [1:0]  v_op  [8];
    logic [15:0] v_exp [8];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vec(input int i, input logic [15:0] d, input logic [3:0] c,
                       input logic [1:0] op, input logic [15:0] e);
        v_in[i] = d; v_cnt[i] = c; v_op[i] = op; v_exp[i] = e;
    endtask

    task automatic drive(input int i);
        bus.In = v_in[i]; bus.Cnt = v_cnt[i]; bus.Op = v_op[i]; bus.in_valid = 1'b1;
    endtask

    // Independent whole-word reference shifter.
    function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] c,
                                              input logic [1:0] op);
        logic [31:0] dd;
        dd = {d, d} << c;
        case (op)
            2'b00:   return dd[31:16];
            2'b01:   return d << c;
            2'b10:   return 16'($signed(d) >>> c);
            default: return d >> c;
        endcase
    endfunction

    // Back-to-back stream into an empty pipe with out_ready held high.
    task automatic run_stream(input string tag, input int n);
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < n + 3; cyc++) begin
            if (cyc < n) drive(cyc);
            else bus.in_valid = 1'b0;
            tick();
            if (cyc < 3) begin
                check({tag, "_latency"}, {15'd0, bus.out_valid}, 16'd0);
            end else begin
                check({tag, "_valid"}, {15'd0, bus.out_valid}, 16'd1);
                check({tag, "_out"}, bus.Out, v_exp[cyc-3]);
`ifdef SHIFT_PIPE_ZERO_EN
                check({tag, "_zero"}, {15'd0, bus.Zero}, {15'd0, v_exp[cyc-3] == 16'h0000});
`endif
            end
        end
        bus.in_valid = 1'b0;
        tick();
        check({tag, "_drained"}, {15'd0, bus.out_valid}, 16'd0);
    endtask

    logic [15:0] exp_q [$];
    logic [15:0] held_out;
    logic        was_stalled;
    int          sent;
    int          got;
    int          cycles;

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0;
        bus.In = 16'h0000; bus.Cnt = 4'h0; bus.Op = 2'b00;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        tick(); tick();
        check("rst_valid", {15'd0, bus.out_valid}, 16'd0);
        check("rst_out", bus.Out, 16'h0000);
        check("rst_in_ready", {15'd0, bus.in_ready}, 16'd1);
`ifdef SHIFT_PIPE_ZERO_EN
        check("rst_zero", {15'd0, bus.Zero}, 16'd1);
`endif
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Rotate with exact latency.
        vec(0, 16'h8001, 4'd1, 2'b00, 16'h0003);
        run_stream("rotl", 1);

        // Arithmetic then logical right shift on consecutive cycles.
        vec(0, 16'h8000, 4'd15, 2'b10, 16'hFFFF);
        vec(1, 16'h8000, 4'd15, 2'b11, 16'h0001);
        run_stream("sr", 2);

        // Left shift plus zero count for every op.
        vec(0, 16'h00FF, 4'd8, 2'b01, 16'hFF00);
        vec(1, 16'h1234, 4'd0, 2'b00, 16'h1234);
        vec(2, 16'h1234, 4'd0, 2'b01, 16'h1234);
        vec(3, 16'h1234, 4'd0, 2'b10, 16'h1234);
        vec(4, 16'h1234, 4'd0, 2'b11, 16'h1234);
        run_stream("sll_cnt0", 5);

`ifdef SHIFT_PIPE_ZERO_EN
        vec(0, 16'h00FF, 4'd8, 2'b11, 16'h0000);
        vec(1, 16'h0F00, 4'd4, 2'b01, 16'hF000);
        run_stream("zero", 2);
`endif

        // Backpressure: only four requests fit while the consumer stalls.
        vec(0, 16'h0001, 4'd4, 2'b01, 16'h0010);
        vec(1, 16'hF000, 4'd4, 2'b11, 16'h0F00);
        vec(2, 16'hF000, 4'd4, 2'b10, 16'hFF00);
        vec(3, 16'h1234, 4'd4, 2'b00, 16'h2341);
        vec(4, 16'h8421, 4'd1, 2'b11, 16'h4210);
        vec(5, 16'hABCD, 4'd8, 2'b00, 16'hCDAB);
        bus.out_ready = 1'b0;
        sent = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            drive(sent < 6 ? sent : 5);
            #1;
            if (bus.in_ready) sent++;
            tick();
        end
        check("bp_accepted", 16'(sent), 16'd4);
        check("bp_in_ready", {15'd0, bus.in_ready}, 16'd0);
        check("bp_valid", {15'd0, bus.out_valid}, 16'd1);
        check("bp_hold_out", bus.Out, v_exp[0]);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (sent < 6) begin drive(sent); sent++; end
            else bus.in_valid = 1'b0;
            check("bp_drain_valid", {15'd0, bus.out_valid}, 16'd1);
            check("bp_drain_out", bus.Out, v_exp[i]);
            tick();
        end
        bus.in_valid = 1'b0;
        check("bp_empty", {15'd0, bus.out_valid}, 16'd0);

        // Reset with three requests in flight, plus a request offered during reset.
        vec(0, 16'h0001, 4'd1, 2'b01, 16'h0002);
        vec(1, 16'h0002, 4'd1, 2'b01, 16'h0004);
        vec(2, 16'h0004, 4'd1, 2'b01, 16'h0008);
        for (int i = 0; i < 3; i++) begin drive(i); tick(); end
        rst_n = 1'b0;
        drive(0);
        tick();
        check("mid_rst_valid", {15'd0, bus.out_valid}, 16'd0);
        check("mid_rst_out", bus.Out, 16'h0000);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.out_valid) got++;
        end
        check("mid_rst_no_stale", 16'(got), 16'd0);

        // Randomized traffic against the reference model.
        sent = 0; got = 0; cycles = 0; was_stalled = 1'b0; held_out = 16'h0000;
        while (got < 1000 && cycles < 20000) begin
            bus.in_valid  = (sent < 1000) && ($urandom_range(3) != 0);
            bus.In        = 16'($urandom);
            bus.Cnt       = 4'($urandom);
            bus.Op        = 2'($urandom);
            bus.out_ready = ($urandom_range(2) != 0);
            #1;
            if (was_stalled) begin
                check("rnd_stall_valid", {15'd0, bus.out_valid}, 16'd1);
                check("rnd_stall_hold", bus.Out, held_out);
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_shift(bus.In, bus.Cnt, bus.Op));
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("rnd_spurious", bus.Out, 16'hxxxx);
                else check("rnd_out", bus.Out, exp_q.pop_front());
                got++;
            end
            was_stalled = bus.out_valid && !bus.out_ready;
            held_out    = bus.Out;
            tick();
            cycles++;
        end
        check("rnd_count", 16'(got), 16'd1000);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("rnd_left_over", 16'(exp_q.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
